// File: rtl/gameover_anim.sv
// Game-over graphic generator: a skull with two blinking eyes that slides
// down into place once the game ends. It runs beside the VGA pixel pipeline
// and gives registered per-pixel flags for the colour mux.
module gameover_anim #(
    parameter int X0         = 204,  // final left edge, pixels
    parameter int Y0         = 228,  // final top edge, pixels
    parameter int CELL_LOG2  = 3,    // log2 of cell size in pixels
    parameter int SLIDE_PX   = 64,   // starting offset above Y0
    parameter int SLIDE_STEP = 4,    // pixels moved per frame during slide
    parameter int EYE_ON     = 30,   // frames lit per blink period
    parameter int EYE_OFF    = 10    // frames dark per blink period
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] x,
    input  logic signed [10:0] y,
    input  logic               frame_start,
    input  logic               gameover,
    output logic               skull,
    output logic               eyes,
    output logic               anim_done
);

    localparam int CNT_MAX = (EYE_ON > EYE_OFF) ? EYE_ON : EYE_OFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int OFF_W   = (SLIDE_PX > 0) ? $clog2(SLIDE_PX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLIDE = 2'd1,
        SHOW  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eye_lit_q, eye_lit_d;
    logic               skull_q, skull_d;
    logic               eyes_q, eyes_d;

    // Half-open range test on a non-negative cell coordinate.
    function automatic logic in_rng(input logic [11:0] v, input int lo, input int hi);
        return (v >= 12'(lo)) && (v < 12'(hi));
    endfunction

    // Offset after one slide step, saturating at zero.
    logic [OFF_W-1:0] slide_nxt;
    assign slide_nxt = (32'(offset_q) <= 32'(SLIDE_STEP)) ? '0
                                                           : offset_q - OFF_W'(SLIDE_STEP);

    // State register and animation bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            cnt_q     <= '0;
            eye_lit_q <= 1'b0;
            skull_q   <= 1'b0;
            eyes_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            eye_lit_q <= eye_lit_d;
            skull_q   <= skull_d;
            eyes_q    <= eyes_d;
        end
    end

    // Next-state logic: slide schedule, blink schedule and abort on gameover low.
    // NOTE: every variable gets a default before the branches so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        cnt_d     = cnt_q;
        eye_lit_d = eye_lit_q;

        if (!gameover) begin
            // Dropping gameover wins over any frame_start in the same cycle.
            state_d   = IDLE;
            offset_d  = '0;
            cnt_d     = '0;
            eye_lit_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Entering the animation does not wait for a frame boundary.
                    state_d   = SLIDE;
                    offset_d  = OFF_W'(SLIDE_PX);
                    cnt_d     = '0;
                    eye_lit_d = 1'b0;
                end
                SLIDE: begin
                    if (frame_start) begin
                        offset_d = slide_nxt;
                        if (slide_nxt == '0) begin
                            state_d   = SHOW;
                            eye_lit_d = 1'b1;
                            cnt_d     = '0;
                        end
                    end
                end
                SHOW: begin
                    if (frame_start) begin
                        if ((eye_lit_q && cnt_q == CNT_W'(EYE_ON - 1)) ||
                            (!eye_lit_q && cnt_q == CNT_W'(EYE_OFF - 1))) begin
                            eye_lit_d = !eye_lit_q;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel classification against the current origin (X0, Y0 - offset).
    logic signed [11:0] rx, ry, org_y;
    logic [11:0]        cx, cy;
    logic               in_area, face, hole, eye_hit, active;

    always_comb begin
        org_y   = 12'(Y0) - 12'(offset_q);
        rx      = {x[10], x} - 12'(X0);
        ry      = {y[10], y} - org_y;
        cx      = rx >>> CELL_LOG2;
        cy      = ry >>> CELL_LOG2;
        in_area = !rx[11] && !ry[11];

        face = in_rng(cx, 0, 21) && in_rng(cy, 7, 13);
        hole = (in_rng(cx, 10, 12) && in_rng(cy, 8, 13)) ||
               (in_rng(cx, 19, 21) && in_rng(cy, 8, 13)) ||
               (in_rng(cx, 12, 19) && in_rng(cy, 9, 11)) ||
               (in_rng(cx, 12, 13) && in_rng(cy, 11, 13)) ||
               (in_rng(cx, 18, 19) && in_rng(cy, 11, 13));
        eye_hit = (in_rng(cx, 11, 14) || in_rng(cx, 17, 20)) && in_rng(cy, 0, 3);

        // Blank while idle and on the edge that returns to idle.
        active  = (state_q != IDLE) && (state_d != IDLE);
        skull_d = active && in_area && face && !hole;
        eyes_d  = active && in_area && eye_hit && eye_lit_q;
    end

    assign skull     = skull_q;
    assign eyes      = eyes_q;
    assign anim_done = (state_q == SHOW);

endmodule

// File: tb/tb_gameover_anim.sv
// Directed bench for gameover_anim: an independent model of the animation
// predicts each registered pixel result, queued at drive time and checked
// one clock later.
module tb_gameover_anim;

    localparam int X0         = 204;
    localparam int Y0         = 228;
    localparam int CELL       = 8;
    localparam int SLIDE_PX   = 64;
    localparam int SLIDE_STEP = 4;
    localparam int EYE_ON     = 30;
    localparam int EYE_OFF    = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [10:0] x, y;
    logic               frame_start, gameover;
    logic               skull, eyes, anim_done;

    gameover_anim dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .gameover   (gameover),
        .skull      (skull),
        .eyes       (eyes),
        .anim_done  (anim_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  skull;
        logic  eyes;
        logic  done;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {M_IDLE, M_SLIDE, M_SHOW} m_state_e;
    m_state_e m_st  = M_IDLE;
    int       m_off = 0;
    int       m_cnt = 0;
    bit       m_lit = 0;
    bit       g_gov = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit rng(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Shape lookup from the bench's own origin; bit1 = skull, bit0 = eyes.
    function automatic logic [1:0] model_pix(input int px, input int py);
        int rx, ry, cx, cy;
        bit sk, ey, hole;
        rx = px - X0;
        ry = py - (Y0 - m_off);
        if (rx < 0 || ry < 0) return 2'b00;
        cx = rx / CELL;
        cy = ry / CELL;
        hole = (rng(cx, 10, 12) && rng(cy, 8, 13)) || (rng(cx, 19, 21) && rng(cy, 8, 13)) ||
               (rng(cx, 12, 19) && rng(cy, 9, 11)) || (rng(cx, 12, 13) && rng(cy, 11, 13)) ||
               (rng(cx, 18, 19) && rng(cy, 11, 13));
        sk = rng(cx, 0, 21) && rng(cy, 7, 13) && !hole;
        ey = (rng(cx, 11, 14) || rng(cx, 17, 20)) && rng(cy, 0, 3) && m_lit;
        return {sk, ey};
    endfunction

    task automatic model_step(input bit gov, input bit fs);
        if (!gov) begin
            m_st = M_IDLE; m_off = 0; m_cnt = 0; m_lit = 0;
        end else if (m_st == M_IDLE) begin
            m_st = M_SLIDE; m_off = SLIDE_PX; m_cnt = 0; m_lit = 0;
        end else if (fs && m_st == M_SLIDE) begin
            m_off = (m_off <= SLIDE_STEP) ? 0 : m_off - SLIDE_STEP;
            if (m_off == 0) begin
                m_st = M_SHOW; m_lit = 1; m_cnt = 0;
            end
        end else if (fs && m_st == M_SHOW) begin
            m_cnt++;
            if (m_lit && m_cnt == EYE_ON) begin
                m_lit = 0; m_cnt = 0;
            end else if (!m_lit && m_cnt == EYE_OFF) begin
                m_lit = 1; m_cnt = 0;
            end
        end
    endtask

    // One clock: drive inputs, predict the registered outputs, compare after the edge.
    task automatic cycle(input string tag, input int px, input int py,
                         input bit gov, input bit fs, input bit cmp);
        logic [1:0] p;
        bit         was_active;
        exp_t       e;
        x = 11'(px);
        y = 11'(py);
        gameover = gov;
        frame_start = fs;
        g_gov = gov;
        p = model_pix(px, py);
        was_active = (m_st != M_IDLE);
        model_step(gov, fs);
        if (!was_active || m_st == M_IDLE) p = 2'b00;
        if (cmp) sb.push_back('{tag, p[1], p[0], m_st == M_SHOW});
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (cmp) begin
            e = sb.pop_front();
            check({e.tag, ".skull"}, skull, e.skull);
            check({e.tag, ".eyes"}, eyes, e.eyes);
            check({e.tag, ".done"}, anim_done, e.done);
        end
    endtask

    task automatic probe(input string tag, input int px, input int py);
        cycle(tag, px, py, g_gov, 1'b0, 1'b1);
    endtask

    task automatic frame();
        cycle("frame", 0, 0, g_gov, 1'b1, 1'b0);
    endtask

    task automatic run_to_show();
        while (m_st != M_SHOW) frame();
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".skull"}, skull, 1'b0);
        check({tag, ".eyes"}, eyes, 1'b0);
        check({tag, ".done"}, anim_done, 1'b0);
        m_st = M_IDLE; m_off = 0; m_cnt = 0; m_lit = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        model_step(g_gov, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; x = '0; y = '0; frame_start = 1'b0; gameover = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.skull", skull, 1'b0);
        check("reset.eyes", eyes, 1'b0);
        check("reset.done", anim_done, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle: nothing drawn anywhere, frame_start ignored.
        for (int px = 0; px < 800; px += 40)
            for (int py = 0; py < 600; py += 24)
                probe("idle", px, py);
        frame();
        frame();

        // Start: immediate entry into the slide at full offset.
        cycle("enter", 210, 220, 1'b1, 1'b0, 1'b1);
        probe("start_top", 210, Y0 - SLIDE_PX + 56);
        probe("start_above", 210, Y0 - SLIDE_PX + 55);

        // Slide: top skull row follows the offset every frame.
        for (int i = 1; i <= 16; i++) begin
            frame();
            probe("slide_top", 210, Y0 - m_off + 56);
            probe("slide_above", 210, Y0 - m_off + 55);
            if (i == 8) begin
                probe("mid_258", 210, 258);
                probe("mid_290", 210, 290);
                probe("mid_300", 210, 300);
            end
        end
        probe("show_face", 210, 290);
        probe("show_mouth", 290, 296);
        probe("show_eye2", 350, 236);

        // Blink: one full on/off period plus a little.
        for (int f = 0; f < 44; f++) begin
            probe("blink_eye", 300, 236);
            probe("blink_gap", 250, 236);
            frame();
        end

        // Abort mid-slide with a simultaneous frame_start.
        cycle("drop", 0, 0, 1'b0, 1'b0, 1'b1);
        cycle("rise", 0, 0, 1'b1, 1'b0, 1'b1);
        frame(); frame(); frame();
        probe("pre_abort", 210, 232);
        cycle("abort", 210, 232, 1'b0, 1'b1, 1'b1);
        probe("after_abort", 210, 232);
        cycle("restart", 210, 220, 1'b1, 1'b0, 1'b1);
        probe("restart_top", 210, 220);
        probe("restart_above", 210, 219);

        // Asynchronous reset in SHOW, once on a skull pixel and once on a lit eye.
        run_to_show();
        probe("pre_rst_skull", 210, 290);
        x = 11'(210); y = 11'(290);
        async_reset("arst_skull");
        probe("post_rst", 210, 290);
        run_to_show();
        probe("pre_rst_eye", 300, 236);
        x = 11'(300); y = 11'(236);
        async_reset("arst_eye");
        probe("post_rst_eye", 300, 236);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
